// File: rtl/bcd_uart_tx.sv
// bcd_uart_tx: sends a packed BCD number as ASCII characters over a UART line.
//
// Each message is DIGITS characters, most significant digit first. Digit values
// 0..9 become '0'..'9'; values 10..15 become '?'. When SEND_CRLF=1 the message
// is followed by CR and LF. Frames are 1 start bit, 8 data bits LSB first, an
// optional parity bit and STOP_BITS stop bits. Characters follow one another
// with no idle time between them.
//
// Parameters:
//   DIGITS       BCD digits per message (1..8)
//   CLKS_PER_BIT clk cycles per serial bit (2..65535)
//   PARITY       0 none, 1 even, 2 odd
//   STOP_BITS    1 or 2
//   SEND_CRLF    1 appends CR, LF after the digits
//
// Ports:
//   clk     sole clock, rising edge
//   rst     asynchronous active-high reset
//   bcd     digit i in bits [4i+3:4i], digit DIGITS-1 most significant
//   start   message request, ignored while busy
//   busy    high while a message is in progress
//   done    one-cycle pulse on the edge that ends the last stop bit
//   tx_out  registered serial line, idle high
module bcd_uart_tx #(
  parameter int DIGITS       = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SEND_CRLF    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  tx_out
);

  localparam int NCHARS = DIGITS + 2 * SEND_CRLF;
  localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_CHAR = 4'(NCHARS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                state;
  logic [CW-1:0]         clk_cnt;
  logic [2:0]            bit_idx;
  logic                  stop_idx;
  logic [3:0]            char_idx;
  logic [4*DIGITS-1:0]   shadow;

  logic [3:0]            cur_digit;
  logic [7:0]            cur_char;
  logic                  par_bit;
  logic                  bit_end;

  // Character currently being framed, derived from the captured digits and
  // the character index so no separate data shift register is needed.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (char_idx == 4'(DIGITS - 1 - i)) cur_digit = shadow[4*i +: 4];
    end
    cur_char = (cur_digit > 4'd9) ? 8'h3F : {4'h3, cur_digit};
    if (SEND_CRLF != 0) begin
      if (char_idx == 4'(DIGITS))          cur_char = 8'h0D;
      else if (char_idx == 4'(DIGITS + 1)) cur_char = 8'h0A;
    end
    par_bit = (PARITY == 2) ? ~(^cur_char) : (^cur_char);
    bit_end = (clk_cnt == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      char_idx <= '0;
      // NOTE: the shadow register is plain state, not a memory array, so it
      // is cleared with everything else to give a fully known reset state.
      shadow   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_out   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of state and counters.
      done <= 1'b0;

      // Bit-period counter runs only while a frame is on the line; it wraps
      // to zero at the end of every bit, which also leaves it at zero in IDLE.
      if (state != IDLE) clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            shadow   <= bcd;
            char_idx <= '0;
            clk_cnt  <= '0;
            busy     <= 1'b1;
            tx_out   <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            tx_out  <= cur_char[0];
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                tx_out <= par_bit;
                state  <= PAR;
              end else begin
                stop_idx <= 1'b0;
                tx_out   <= 1'b1;
                state    <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= cur_char[bit_idx + 3'd1];
            end
          end
        end

        PAR: begin
          if (bit_end) begin
            stop_idx <= 1'b0;
            tx_out   <= 1'b1;
            state    <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop_idx == LAST_STOP) begin
              if (char_idx == LAST_CHAR) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                tx_out <= 1'b1;
                state  <= IDLE;
              end else begin
                // Next start bit directly follows the last stop bit.
                char_idx <= char_idx + 4'd1;
                tx_out   <= 1'b0;
                state    <= START;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          busy   <= 1'b0;
          tx_out <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Self-checking bench for bcd_uart_tx. Three instances cover the default
// configuration, even parity with two stop bits, and three digits with CR/LF.
// Expected characters are queued when a message is started and popped as the
// bench's own UART receiver decodes frames from tx_out.
module tb_bcd_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bcd0, bcd1;
  logic [11:0] bcd2;
  logic        start0, start1, start2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        tx0, tx1, tx2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int mon_sel     = 0;

  logic [7:0] exp_q[$];
  logic       tx_m, busy_m, done_m;

  bcd_uart_tx u_def (
    .clk(clk), .rst(rst), .bcd(bcd0), .start(start0),
    .busy(busy0), .done(done0), .tx_out(tx0)
  );

  bcd_uart_tx #(.PARITY(1), .STOP_BITS(2)) u_par (
    .clk(clk), .rst(rst), .bcd(bcd1), .start(start1),
    .busy(busy1), .done(done1), .tx_out(tx1)
  );

  bcd_uart_tx #(.DIGITS(3), .SEND_CRLF(1)) u_crlf (
    .clk(clk), .rst(rst), .bcd(bcd2), .start(start2),
    .busy(busy2), .done(done2), .tx_out(tx2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    tx_m = tx0; busy_m = busy0; done_m = done0;
    case (mon_sel)
      1: begin tx_m = tx1; busy_m = busy1; done_m = done1; end
      2: begin tx_m = tx2; busy_m = busy2; done_m = done2; end
      default: ;
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int frame_bits(input int sel);
    return (sel == 1) ? 12 : 10;
  endfunction

  function automatic int n_chars(input int sel);
    return (sel == 2) ? 5 : 2;
  endfunction

  task automatic set_bcd(input int sel, input logic [31:0] v);
    case (sel)
      1:       bcd1 = v[7:0];
      2:       bcd2 = v[11:0];
      default: bcd0 = v[7:0];
    endcase
  endtask

  task automatic set_start(input int sel, input logic s);
    case (sel)
      1:       start1 = s;
      2:       start2 = s;
      default: start0 = s;
    endcase
  endtask

  task automatic push_msg(input int sel, input logic [31:0] v);
    int digits;
    logic [3:0] d;
    digits = (sel == 2) ? 3 : 2;
    for (int i = digits - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      exp_q.push_back((d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d}));
    end
    if (sel == 2) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Called at a negedge: raises start for one edge and returns the cycle
  // number of the accepting edge.
  task automatic send(input int sel, input logic [31:0] v, output int acc);
    mon_sel = sel;
    set_bcd(sel, v);
    set_start(sel, 1'b1);
    push_msg(sel, v);
    @(negedge clk);
    set_start(sel, 1'b0);
    acc = cyc;
    vectors++;
    if (busy_m !== 1'b1 || tx_m !== 1'b0 || done_m !== 1'b0) begin
      $display("FAIL accept: busy/tx/done = %b/%b/%b, required 1/0/0", busy_m, tx_m, done_m);
      miscompares++;
    end
  endtask

  task automatic rx_frame(input int sel, output logic [7:0] data, output logic par,
                          output int st, output bit ok);
    int n;
    int nstop;
    nstop = (sel == 1) ? 2 : 1;
    data = '0; par = 1'b0; st = 0; ok = 1'b1;
    n = 0;
    while (tx_m !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (tx_m !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    st = cyc;
    repeat (8) @(negedge clk);
    vectors++;
    if (tx_m !== 1'b0) begin
      $display("FAIL start_bit: line %b at mid start bit, required 0", tx_m);
      miscompares++;
    end
    for (int j = 0; j < 8; j++) begin
      repeat (16) @(negedge clk);
      data[j] = tx_m;
    end
    if (sel == 1) begin
      repeat (16) @(negedge clk);
      par = tx_m;
    end
    for (int s = 0; s < nstop; s++) begin
      repeat (16) @(negedge clk);
      vectors++;
      if (tx_m !== 1'b1) begin
        $display("FAIL stop_bit%0d: line %b, required 1", s, tx_m);
        miscompares++;
      end
    end
  endtask

  // Decodes a whole message while watching busy/done; returns at the negedge
  // on which done is seen, so the caller can start the next message there.
  task automatic check_msg(input int sel, input int acc, input string tag);
    int fb, nc, dur, n, st;
    bit ok, busy_drop;
    logic [7:0] d, e;
    logic p;
    fb  = frame_bits(sel);
    nc  = n_chars(sel);
    dur = 16 * fb * nc;
    fork
      begin
        for (int c = 0; c < nc; c++) begin
          rx_frame(sel, d, p, st, ok);
          vectors++;
          if (!ok) begin
            $display("FAIL %s_char%0d: no start bit seen, required a frame", tag, c);
            miscompares++;
            break;
          end
          e = 8'hxx;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          if (d !== e) begin
            $display("FAIL %s_char%0d: got %h, required %h", tag, c, d, e);
            miscompares++;
          end
          vectors++;
          if (st != acc + c * fb * 16) begin
            $display("FAIL %s_char%0d_start: start bit at cycle %0d, required %0d",
                     tag, c, st, acc + c * fb * 16);
            miscompares++;
          end
          if (sel == 1) begin
            vectors++;
            if (p !== ^e) begin
              $display("FAIL %s_char%0d_parity: got %b, required %b", tag, c, p, ^e);
              miscompares++;
            end
          end
        end
      end
      begin
        n = 0;
        busy_drop = 1'b0;
        while (done_m !== 1'b1 && n < dur + 64) begin
          if (busy_m !== 1'b1) busy_drop = 1'b1;
          @(negedge clk);
          n++;
        end
        vectors++;
        if (done_m !== 1'b1 || cyc - acc != dur) begin
          $display("FAIL %s_duration: done=%b after %0d cycles, required 1 after %0d",
                   tag, done_m, cyc - acc, dur);
          miscompares++;
        end
        vectors++;
        if (busy_drop || busy_m !== 1'b0) begin
          $display("FAIL %s_busy: dropped early=%b, busy at done=%b, required 0/0",
                   tag, busy_drop, busy_m);
          miscompares++;
        end
      end
    join
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bcd0 = '0; bcd1 = '0; bcd2 = '0;
    #1;
    vectors++;
    if ({tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2} !== 9'b111_000_000) begin
      $display("FAIL reset_outputs: tx/busy/done = %b%b%b/%b%b%b/%b%b%b, required 111/000/000",
               tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2);
      miscompares++;
    end
    // start held across edges during reset must not launch a message
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    repeat (2) @(negedge clk);
    start0 = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
      $display("FAIL start_in_reset: busy=%b tx=%b, required 0/1", busy0, tx0);
      miscompares++;
    end
  endtask

  task automatic test_basic;
    int acc;
    send(0, 32'h07, acc);
    check_msg(0, acc, "basic");
    @(negedge clk);
    vectors++;
    if (done0 !== 1'b0) begin
      $display("FAIL done_pulse: done=%b one cycle later, required 0", done0);
      miscompares++;
    end
  endtask

  task automatic test_bcd_change;
    int acc;
    @(negedge clk);
    send(0, 32'h07, acc);
    fork
      check_msg(0, acc, "shadow");
      begin
        while (cyc < acc + 290) @(negedge clk);
        bcd0 = 8'h15;
      end
    join
    @(negedge clk);
    send(0, 32'h15, acc);
    check_msg(0, acc, "after_change");
  endtask

  task automatic test_invalid_digit;
    int acc;
    @(negedge clk);
    send(0, 32'hA3, acc);
    check_msg(0, acc, "invalid");
  endtask

  task automatic test_parity;
    int acc;
    @(negedge clk);
    send(1, 32'h77, acc);
    check_msg(1, acc, "parity");
  endtask

  task automatic test_back_to_back;
    int acc, acc2, done_at;
    @(negedge clk);
    send(2, 32'h125, acc);
    check_msg(2, acc, "crlf");
    done_at = cyc;
    send(2, 32'h980, acc2);
    vectors++;
    if (acc2 != done_at + 1) begin
      $display("FAIL b2b_accept: accepted at %0d, required %0d", acc2, done_at + 1);
      miscompares++;
    end
    check_msg(2, acc2, "b2b");
  endtask

  task automatic test_start_ignored;
    int acc;
    bit seen;
    @(negedge clk);
    send(0, 32'h64, acc);
    fork
      check_msg(0, acc, "ignored");
      begin
        repeat (20) @(negedge clk);
        start0 = 1'b1;
        repeat (100) @(negedge clk);
        start0 = 1'b0;
      end
    join
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || tx0 !== 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      $display("FAIL start_ignored: activity after done = %b, required 0", seen);
      miscompares++;
    end
  endtask

  task automatic test_mid_reset;
    int acc;
    bit seen;
    @(negedge clk);
    send(0, 32'h58, acc);
    exp_q.delete();
    // char 1 is 0x38; data bit 1 (a zero) is on the line here
    while (cyc < acc + 200) @(negedge clk);
    vectors++;
    if (tx0 !== 1'b0) begin
      $display("FAIL pre_reset_line: tx=%b, required 0", tx0);
      miscompares++;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      $display("FAIL async_reset: tx/busy/done = %b/%b/%b, required 1/0/0", tx0, busy0, done0);
      miscompares++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0 || tx0 !== 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      $display("FAIL aborted_msg: activity after reset = %b, required 0", seen);
      miscompares++;
    end
    send(0, 32'h42, acc);
    check_msg(0, acc, "fresh");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bcd_change();
    test_invalid_digit();
    test_parity();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
